// File: rtl/buffered_uart.sv
// buffered_uart: FIFO-buffered UART, configurable divisor/width/parity/stop.
// Ports: clk,rst_n; TX wr_en,din,tx_full,tx_busy,tx; RX rx,rdy,rd_en,dout,rx_level; flags+err_clr.
module buffered_uart #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_DEPTH  = 8,
  parameter int RX_DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_BITS-1:0]       din,
  output logic                       tx_full,
  output logic                       tx_busy,
  output logic                       tx,
  input  logic                       rx,
  output logic                       rdy,
  input  logic                       rd_en,
  output logic [DATA_BITS-1:0]       dout,
  output logic [$clog2(RX_DEPTH):0]  rx_level,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overrun,
  input  logic                       err_clr
);
  localparam int DIV_R = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int DIV   = (DIV_R < 4) ? 4 : DIV_R;
  localparam int CW    = $clog2(STOP_BITS * DIV);
  localparam int BW    = $clog2(DATA_BITS);
  localparam int TAW   = $clog2(TX_DEPTH);
  localparam int RAW   = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic HAS_PAR = (PARITY != 0);
  localparam logic ODD     = (PARITY == 1);

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tmem_q [TX_DEPTH];
  logic [TAW-1:0]       twp_q, trp_q;
  logic [TAW:0]         tcnt_q;
  logic                 tpush, tpop, tnemp;
  logic [DATA_BITS-1:0] thead;

  assign tx_full = (tcnt_q == (TAW+1)'(TX_DEPTH));
  assign tpush   = wr_en & ~tx_full;
  assign tnemp   = (tcnt_q != '0);
  assign thead   = tmem_q[trp_q];

  always_ff @(posedge clk) begin
    if (tpush) tmem_q[twp_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      twp_q  <= '0;
      trp_q  <= '0;
      tcnt_q <= '0;
    end else begin
      if (tpush) twp_q <= twp_q + 1'b1;
      if (tpop)  trp_q <= trp_q + 1'b1;
      if (tpush & ~tpop)      tcnt_q <= tcnt_q + 1'b1;
      else if (tpop & ~tpush) tcnt_q <= tcnt_q - 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP
  } tx_st_e;

  tx_st_e               ts_q, ts_d;
  logic [CW-1:0]        tc_q, tc_d;
  logic [BW-1:0]        tb_q, tb_d;
  logic [DATA_BITS-1:0] tsh_q, tsh_d;
  logic                 tpar_q, tpar_d;
  logic                 tx_q, tx_d;
  logic                 busy_q;

  always_comb begin
    ts_d   = ts_q;
    tc_d   = tc_q;
    tb_d   = tb_q;
    tsh_d  = tsh_q;
    tpar_d = tpar_q;
    tx_d   = 1'b1;
    tpop   = 1'b0;
    unique case (ts_q)
      T_IDLE: begin
        if (tnemp) begin
          tpop   = 1'b1;
          tsh_d  = thead;
          tpar_d = (^thead) ^ ODD;
          tc_d   = '0;
          ts_d   = T_START;
        end
      end
      T_START: begin
        tx_d = 1'b0;
        if (tc_q == BIT_END) begin
          tc_d = '0;
          tb_d = '0;
          ts_d = T_DATA;
        end else tc_d = tc_q + 1'b1;
      end
      T_DATA: begin
        tx_d = tsh_q[0];
        if (tc_q == BIT_END) begin
          tc_d  = '0;
          tsh_d = tsh_q >> 1;
          if (tb_q == LAST_BIT) ts_d = HAS_PAR ? T_PAR : T_STOP;
          else tb_d = tb_q + 1'b1;
        end else tc_d = tc_q + 1'b1;
      end
      T_PAR: begin
        tx_d = tpar_q;
        if (tc_q == BIT_END) begin
          tc_d = '0;
          ts_d = T_STOP;
        end else tc_d = tc_q + 1'b1;
      end
      T_STOP: begin
        if (tc_q == STOP_END) begin
          tc_d = '0;
          // chain straight into the next frame with no idle gap
          if (tnemp) begin
            tpop   = 1'b1;
            tsh_d  = thead;
            tpar_d = (^thead) ^ ODD;
            ts_d   = T_START;
          end else ts_d = T_IDLE;
        end else tc_d = tc_q + 1'b1;
      end
      default: ts_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q   <= T_IDLE;
      tc_q   <= '0;
      tb_q   <= '0;
      tsh_q  <= '0;
      tpar_q <= 1'b0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      ts_q   <= ts_d;
      tc_q   <= tc_d;
      tb_q   <= tb_d;
      tsh_q  <= tsh_d;
      tpar_q <= tpar_d;
      tx_q   <= tx_d;
      // tx lags the state by one cycle, so busy does too
      busy_q <= tpush | tnemp | (ts_q != T_IDLE);
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

  // ---------------- RX FSM ----------------
  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BREAK
  } rx_st_e;

  rx_st_e               rs_q, rs_d;
  logic [CW-1:0]        rc_q, rc_d;
  logic [BW-1:0]        rb_q, rb_d;
  logic [DATA_BITS-1:0] rsh_q, rsh_d;
  logic                 rperr_q, rperr_d;
  logic                 rx_push_q, rx_push_d;
  logic                 rs1_q, rs2_q, rprev_q;
  logic                 pe_set, fe_set, ov_set;

  always_comb begin
    rs_d      = rs_q;
    rc_d      = rc_q;
    rb_d      = rb_q;
    rsh_d     = rsh_q;
    rperr_d   = rperr_q;
    rx_push_d = 1'b0;
    pe_set    = 1'b0;
    fe_set    = 1'b0;
    unique case (rs_q)
      R_IDLE: begin
        if (rprev_q & ~rs2_q) begin
          rc_d    = '0;
          rperr_d = 1'b0;
          rs_d    = R_START;
        end
      end
      R_START: begin
        if (rc_q == HALF_END) begin
          rc_d = '0;
          rb_d = '0;
          rs_d = rs2_q ? R_IDLE : R_DATA;
        end else rc_d = rc_q + 1'b1;
      end
      R_DATA: begin
        if (rc_q == BIT_END) begin
          rc_d  = '0;
          rsh_d = {rs2_q, rsh_q[DATA_BITS-1:1]};
          if (rb_q == LAST_BIT) rs_d = HAS_PAR ? R_PAR : R_STOP;
          else rb_d = rb_q + 1'b1;
        end else rc_d = rc_q + 1'b1;
      end
      R_PAR: begin
        if (rc_q == BIT_END) begin
          rc_d    = '0;
          rperr_d = rs2_q ^ (^rsh_q) ^ ODD;
          rs_d    = R_STOP;
        end else rc_d = rc_q + 1'b1;
      end
      R_STOP: begin
        if (rc_q == BIT_END) begin
          rc_d = '0;
          if (rs2_q) begin
            rx_push_d = 1'b1;
            pe_set    = rperr_q;
            rs_d      = R_IDLE;
          end else begin
            fe_set = 1'b1;
            rs_d   = R_BREAK;
          end
        end else rc_d = rc_q + 1'b1;
      end
      R_BREAK: begin
        if (rs2_q) rs_d = R_IDLE;
      end
      default: rs_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q      <= R_IDLE;
      rc_q      <= '0;
      rb_q      <= '0;
      rsh_q     <= '0;
      rperr_q   <= 1'b0;
      rx_push_q <= 1'b0;
      rs1_q     <= 1'b1;
      rs2_q     <= 1'b1;
      rprev_q   <= 1'b1;
    end else begin
      rs_q      <= rs_d;
      rc_q      <= rc_d;
      rb_q      <= rb_d;
      rsh_q     <= rsh_d;
      rperr_q   <= rperr_d;
      rx_push_q <= rx_push_d;
      rs1_q     <= rx;
      rs2_q     <= rs1_q;
      rprev_q   <= rs2_q;
    end
  end

  // ---------------- RX FIFO ----------------
  // rsh_q holds the word until the next frame's data phase, so it
  // is still valid the cycle after rx_push_q is raised.
  logic [DATA_BITS-1:0] rmem_q [RX_DEPTH];
  logic [RAW-1:0]       rwp_q, rrp_q, rrp_nx;
  logic [RAW:0]         rcnt_q, rcnt_d;
  logic                 rfull, rpush, rpop, rdy_q;
  logic [DATA_BITS-1:0] dout_q, dout_d;

  assign rfull  = (rcnt_q == (RAW+1)'(RX_DEPTH));
  assign rpop   = rd_en & (rcnt_q != '0);
  assign rpush  = rx_push_q & (~rfull | rpop);
  assign ov_set = rx_push_q & rfull & ~rpop;
  assign rrp_nx = rrp_q + 1'b1;

  always_comb begin
    rcnt_d = rcnt_q;
    if (rpush & ~rpop)      rcnt_d = rcnt_q + 1'b1;
    else if (rpop & ~rpush) rcnt_d = rcnt_q - 1'b1;
  end

  // registered first-word fall-through head
  always_comb begin
    dout_d = dout_q;
    if (rpop) begin
      if (rcnt_q == (RAW+1)'(1)) begin
        if (rpush) dout_d = rsh_q;
      end else dout_d = rmem_q[rrp_nx];
    end else if ((rcnt_q == '0) && rpush) begin
      dout_d = rsh_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rpush) rmem_q[rwp_q] <= rsh_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rwp_q  <= '0;
      rrp_q  <= '0;
      rcnt_q <= '0;
      rdy_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      if (rpush) rwp_q <= rwp_q + 1'b1;
      if (rpop)  rrp_q <= rrp_nx;
      rcnt_q <= rcnt_d;
      rdy_q  <= (rcnt_d != '0);
      dout_q <= dout_d;
    end
  end

  assign rdy      = rdy_q;
  assign dout     = dout_q;
  assign rx_level = rcnt_q;

  // ---------------- sticky flags (set wins) ----------------
  logic pe_q, fe_q, ov_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      pe_q <= pe_set | (pe_q & ~err_clr);
      fe_q <= fe_set | (fe_q & ~err_clr);
      ov_q <= ov_set | (ov_q & ~err_clr);
    end
  end

  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;

endmodule
